// File: rtl/dsi_packet_arbiter.sv
// Shares the DSI packet assembler request port between video (priority) and a host command queue.
// Optional stall timeout on command grants: define DSI_ARB_TIMEOUT_EN.
module dsi_packet_arbiter #(
  parameter int g_pixels_per_clock = 1,
  parameter int g_timeout_cycles   = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            v_req_i,
  input  logic                            v_islong_i,
  input  logic [5:0]                      v_type_i,
  input  logic [15:0]                     v_wcount_i,
  input  logic [15:0]                     v_command_i,
  input  logic                            v_last_i,
  input  logic [24*g_pixels_per_clock-1:0] v_payload_i,
  output logic                            v_dreq_o,
  input  logic                            c_req_i,
  input  logic                            c_islong_i,
  input  logic [5:0]                      c_type_i,
  input  logic [15:0]                     c_wcount_i,
  input  logic [15:0]                     c_command_i,
  input  logic [24*g_pixels_per_clock-1:0] c_payload_i,
  output logic                            c_dreq_o,
  output logic                            c_ack_o,
  input  logic                            cmd_enable_i,
  output logic                            cmd_busy_o,
  output logic                            err_o,
  output logic                            p_req_o,
  output logic                            p_islong_o,
  output logic [5:0]                      p_type_o,
  output logic [15:0]                     p_wcount_o,
  output logic [15:0]                     p_command_o,
  output logic                            p_last_o,
  output logic [24*g_pixels_per_clock-1:0] p_payload_o,
  input  logic                            p_dreq_i
);

  localparam int          PW  = 24*g_pixels_per_clock;
  localparam logic [15:0] BPW = 16'(3*g_pixels_per_clock);

  typedef enum logic [2:0] {S_IDLE, S_VID, S_CMD_HDR, S_CMD_PAY, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] rem, rem_nxt;
  logic        done, abort, ack_q, err_q, in_cmd;

  assign in_cmd = (state == S_CMD_HDR) || (state == S_CMD_PAY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      rem   <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      ack_q <= done | abort;
    end
  end

`ifdef DSI_ARB_TIMEOUT_EN
  logic [15:0] stall;

  // Stall counts consecutive cycles of a command grant without an assembler accept.
  assign abort = in_cmd && !p_dreq_i && (stall == 16'(g_timeout_cycles-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall <= '0;
      err_q <= 1'b0;
    end else begin
      if (abort) err_q <= 1'b1;
      if ((state_nxt != state) || p_dreq_i) stall <= '0;
      else if (in_cmd)                      stall <= stall + 16'd1;
    end
  end
`else
  localparam int unused_timeout = g_timeout_cycles;
  assign abort = 1'b0;
  assign err_q = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    done        = 1'b0;
    v_dreq_o    = 1'b0;
    c_dreq_o    = 1'b0;
    cmd_busy_o  = 1'b0;
    p_req_o     = 1'b0;
    p_islong_o  = 1'b0;
    p_type_o    = '0;
    p_wcount_o  = '0;
    p_command_o = '0;
    p_last_o    = 1'b0;
    p_payload_o = '0;
    case (state)
      S_IDLE: begin
        if (v_req_i)                    state_nxt = S_VID;
        else if (c_req_i && cmd_enable_i) state_nxt = S_CMD_HDR;
      end
      S_VID: begin
        p_req_o     = v_req_i;
        p_islong_o  = v_islong_i;
        p_type_o    = v_type_i;
        p_wcount_o  = v_wcount_i;
        p_command_o = v_command_i;
        p_last_o    = v_last_i;
        p_payload_o = v_payload_i;
        v_dreq_o    = p_dreq_i;
        if (!v_req_i) state_nxt = S_GAP;
      end
      S_CMD_HDR, S_CMD_PAY: begin
        cmd_busy_o  = 1'b1;
        p_req_o     = 1'b1;
        p_islong_o  = c_islong_i;
        p_type_o    = c_type_i;
        p_wcount_o  = c_wcount_i;
        p_command_o = c_command_i;
        p_last_o    = 1'b1;
        if (state == S_CMD_HDR) begin
          if (abort) state_nxt = S_GAP;
          else if (p_dreq_i) begin
            if (!c_islong_i || (c_wcount_i == 16'd0)) begin
              done      = 1'b1;
              state_nxt = S_GAP;
            end else begin
              rem_nxt   = c_wcount_i;
              state_nxt = S_CMD_PAY;
            end
          end
        end else begin
          p_payload_o = c_payload_i[PW-1:0];
          c_dreq_o    = p_dreq_i;
          if (abort) state_nxt = S_GAP;
          else if (p_dreq_i) begin
            // Last word may be partial; rem never goes below zero.
            if (rem <= BPW) begin
              done      = 1'b1;
              state_nxt = S_GAP;
            end else begin
              rem_nxt = rem - BPW;
            end
          end
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign c_ack_o = ack_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dsi_packet_arbiter.sv
// Directed bench for dsi_packet_arbiter (P=1, timeout 16 when DSI_ARB_TIMEOUT_EN is set).
module tb_dsi_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_req, v_islong, v_last, v_dreq;
  logic [5:0]  v_type;
  logic [15:0] v_wcount, v_command;
  logic [23:0] v_payload;
  logic        c_req, c_islong, c_dreq, c_ack, cmd_enable, cmd_busy, err;
  logic [5:0]  c_type;
  logic [15:0] c_wcount, c_command;
  logic [23:0] c_payload;
  logic        p_req, p_islong, p_last, p_dreq;
  logic [5:0]  p_type;
  logic [15:0] p_wcount, p_command;
  logic [23:0] p_payload;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsi_packet_arbiter #(.g_pixels_per_clock(1), .g_timeout_cycles(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .v_req_i(v_req), .v_islong_i(v_islong), .v_type_i(v_type), .v_wcount_i(v_wcount),
    .v_command_i(v_command), .v_last_i(v_last), .v_payload_i(v_payload), .v_dreq_o(v_dreq),
    .c_req_i(c_req), .c_islong_i(c_islong), .c_type_i(c_type), .c_wcount_i(c_wcount),
    .c_command_i(c_command), .c_payload_i(c_payload), .c_dreq_o(c_dreq), .c_ack_o(c_ack),
    .cmd_enable_i(cmd_enable), .cmd_busy_o(cmd_busy), .err_o(err),
    .p_req_o(p_req), .p_islong_o(p_islong), .p_type_o(p_type), .p_wcount_o(p_wcount),
    .p_command_o(p_command), .p_last_o(p_last), .p_payload_o(p_payload), .p_dreq_i(p_dreq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int n_req, n_cdreq, n_vdreq, n_ack;

  initial begin
    rst = 1'b1; p_dreq = 1'b0; cmd_enable = 1'b1;
    v_req = 0; v_islong = 1; v_type = 6'h19; v_wcount = 16'd640; v_command = 16'h0000;
    v_last = 0; v_payload = 24'h123456;
    c_req = 0; c_islong = 0; c_type = 6'h05; c_wcount = 0; c_command = 16'h0029;
    c_payload = 24'hABCDEF;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_p_req", p_req, 0);
    chk("rst_c_ack", c_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", cmd_busy, 0);

    // Short command, assembler accepts after 3 cycles
    c_req = 1; #1;
    chk("short_idle_req", p_req, 0);
    step();
    chk("short_p_req", p_req, 1);
    chk("short_type", p_type, 6'h05);
    chk("short_cmd", p_command, 16'h0029);
    chk("short_last", p_last, 1);
    chk("short_busy", cmd_busy, 1);
    step(); step();
    p_dreq = 1; #1;
    chk("short_no_cdreq", c_dreq, 0);
    step();
    p_dreq = 0; c_req = 0; #1;
    chk("short_gap_req", p_req, 0);
    chk("short_ack", c_ack, 1);
    step();
    chk("short_ack_once", c_ack, 0);

    // Long command, wcount=7 -> 1 header + 3 payload words
    c_islong = 1; c_wcount = 16'd7; c_type = 6'h29; c_req = 1; p_dreq = 1;
    n_req = 0; n_cdreq = 0; n_ack = 0;
    step();
    chk("long_hdr_no_cdreq", c_dreq, 0);
    for (int i = 0; i < 4; i++) begin
      n_req += int'(p_req); n_cdreq += int'(c_dreq); n_ack += int'(c_ack);
      if (i == 1) chk("long_payload", p_payload, 24'hABCDEF);
      step();
    end
    c_req = 0; p_dreq = 0; #1;
    n_req += int'(p_req); n_ack += int'(c_ack);
    step();
    n_ack += int'(c_ack);
    chk("long_req_cycles", n_req, 4);
    chk("long_cdreq", n_cdreq, 3);
    chk("long_ack", n_ack, 1);

    // Simultaneous requests: video wins, command follows after GAP+IDLE
    c_islong = 0; c_type = 6'h15; v_req = 1; c_req = 1;
    step();
    chk("cont_vid_req", p_req, 1);
    chk("cont_vid_type", p_type, 6'h19);
    chk("cont_vid_busy", cmd_busy, 0);
    p_dreq = 1; #1;
    chk("cont_vdreq", v_dreq, 1);
    chk("cont_cdreq", c_dreq, 0);
    step();
    v_req = 0; p_dreq = 0;
    step();
    chk("cont_gap_req", p_req, 0);
    chk("cont_gap_ack", c_ack, 0);
    step();
    chk("cont_idle_busy", cmd_busy, 0);
    step();
    chk("cont_cmd_busy", cmd_busy, 1);
    chk("cont_cmd_type", p_type, 6'h15);
    p_dreq = 1;
    step();
    c_req = 0; p_dreq = 0; #1;
    chk("cont_ack", c_ack, 1);
    step();

    // Video arrives mid-payload: command finishes all 10 words first
    c_islong = 1; c_wcount = 16'd30; c_req = 1; p_dreq = 1;
    step(); step();
    v_req = 1;
    n_cdreq = 0; n_vdreq = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cdreq += int'(c_dreq); n_vdreq += int'(v_dreq);
      if (i == 9) chk("pre_islong_held", p_islong, 1);
      step();
    end
    c_req = 0; #1;
    chk("pre_cdreq_words", n_cdreq, 10);
    chk("pre_vdreq_stalled", n_vdreq, 0);
    chk("pre_ack", c_ack, 1);
    chk("pre_gap_vdreq", v_dreq, 0);
    step();
    chk("pre_idle_vdreq", v_dreq, 0);
    step();
    chk("pre_vid_vdreq", v_dreq, 1);
    v_req = 0; p_dreq = 0;
    step(); step();

    // Reset after 2 payload words abandons the packet
    c_req = 1; p_dreq = 1;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0; c_req = 0; p_dreq = 0; #1;
    chk("rst_mid_req", p_req, 0);
    chk("rst_mid_busy", cmd_busy, 0);
    chk("rst_mid_cdreq", c_dreq, 0);
    chk("rst_mid_ack", c_ack, 0);
    step();
    chk("rst_mid_ack_after", c_ack, 0);

    // Command stalled in header
    c_islong = 0; c_req = 1; p_dreq = 0;
    step();
`ifdef DSI_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk("to_still_busy", cmd_busy, 1);
    chk("to_no_err_yet", err, 0);
    step();
    c_req = 0; #1;
    chk("to_abort_req", p_req, 0);
    chk("to_ack", c_ack, 1);
    chk("to_err", err, 1);
    step(); step();
    chk("to_err_sticky", err, 1);
    rst = 1; step(); rst = 0; #1;
    chk("to_err_cleared", err, 0);
`else
    for (int i = 0; i < 40; i++) step();
    chk("noto_busy", cmd_busy, 1);
    chk("noto_req", p_req, 1);
    chk("noto_err", err, 0);
    chk("noto_ack", c_ack, 0);
    c_req = 0; rst = 1; step(); rst = 0; #1;
    chk("noto_rst_busy", cmd_busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
